// File: rtl/inst_fetch_queue.sv
// Fetch-to-decode decoupling queue: unpacks up to four instructions per fetch line into a
// circular buffer and presents the two oldest entries to the dual decoders in program order.
module inst_fetch_queue #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned PC_W  = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     fq_valid_i,
   output logic                     fq_ready_o,
   input  logic [PC_W-1:0]          fq_pc_i,
   input  logic [127:0]             fq_inst_i,
   input  logic [2:0]               fq_count_i,
   input  logic                     flush_i,
   output logic                     dec1_valid_o,
   output logic [31:0]              dec1_inst_o,
   output logic [PC_W-1:0]          dec1_pc_o,
   output logic                     dec2_valid_o,
   output logic [31:0]              dec2_inst_o,
   output logic [PC_W-1:0]          dec2_pc_o,
   input  logic [1:0]               dec_accept_i,
   output logic [$clog2(DEPTH):0]   occupancy_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [PTR_W:0] READY_MAX = (PTR_W + 1)'(DEPTH - 4);

   logic [31:0]      r_inst [DEPTH];
   logic [PC_W-1:0]  r_pc   [DEPTH];
   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   logic [PTR_W:0]   r_occ;

   logic [1:0]       w_s0;
   logic [2:0]       w_cnt;
   logic [2:0]       w_room;
   logic [2:0]       w_n;
   logic [2:0]       w_n_eff;
   logic             w_fire;
   logic [1:0]       w_d_raw;
   logic [1:0]       w_d;
   logic [PTR_W-1:0] w_head1;

   logic             w_wr_en   [4];
   logic [PTR_W-1:0] w_wr_idx  [4];
   logic [31:0]      w_wr_inst [4];
   logic [PC_W-1:0]  w_wr_pc   [4];

   assign fq_ready_o = (r_occ <= READY_MAX);

   always_comb begin
      w_s0    = fq_pc_i[3:2];
      w_cnt   = (fq_count_i > 3'd4) ? 3'd4 : fq_count_i;
      w_room  = 3'd4 - {1'b0, w_s0};
      w_n     = (w_cnt < w_room) ? w_cnt : w_room;
      w_fire  = fq_valid_i & fq_ready_o & ~flush_i;
      w_n_eff = w_fire ? w_n : 3'd0;
      // 10 decodes as no consumption; dec2 can only be taken together with dec1
      w_d_raw = {dec_accept_i[0] & dec_accept_i[1], dec_accept_i[0] & ~dec_accept_i[1]};
      w_d     = (r_occ < (PTR_W + 1)'(w_d_raw)) ? r_occ[1:0] : w_d_raw;
      w_head1 = r_head + PTR_W'(1);
   end

   always_comb begin
      for (int k = 0; k < 4; k++) begin
         logic [1:0] slot;
         slot         = w_s0 + 2'(k);
         w_wr_en[k]   = w_fire && (3'(k) < w_n);
         w_wr_idx[k]  = r_tail + PTR_W'(k);
         w_wr_inst[k] = fq_inst_i[{slot, 5'b0} +: 32];
         w_wr_pc[k]   = fq_pc_i + PC_W'(4 * k);
      end
   end

   // Storage carries no reset; the valid outputs mask stale entries.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int k = 0; k < 4; k++) begin
            if (w_wr_en[k]) begin
               r_inst[w_wr_idx[k]] <= w_wr_inst[k];
               r_pc[w_wr_idx[k]]   <= w_wr_pc[k];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush_i) begin
         r_head <= '0;
         r_tail <= '0;
         r_occ  <= '0;
      end else begin
         r_head <= r_head + PTR_W'(w_d);
         r_tail <= r_tail + PTR_W'(w_n_eff);
         r_occ  <= r_occ + (PTR_W + 1)'(w_n_eff) - (PTR_W + 1)'(w_d);
      end
   end

   always_comb begin
      dec1_valid_o = (r_occ >= (PTR_W + 1)'(1));
      dec2_valid_o = (r_occ >= (PTR_W + 1)'(2));
      dec1_inst_o  = dec1_valid_o ? r_inst[r_head]  : NOP;
      dec1_pc_o    = dec1_valid_o ? r_pc[r_head]    : '0;
      dec2_inst_o  = dec2_valid_o ? r_inst[w_head1] : NOP;
      dec2_pc_o    = dec2_valid_o ? r_pc[w_head1]   : '0;
      occupancy_o  = r_occ;
   end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scenario bench for inst_fetch_queue; a scoreboard queue models the expected entry stream.
module tb_inst_fetch_queue;

   logic         clk;
   logic         rst;
   logic         fq_valid_i;
   logic         fq_ready_o;
   logic [63:0]  fq_pc_i;
   logic [127:0] fq_inst_i;
   logic [2:0]   fq_count_i;
   logic         flush_i;
   logic         dec1_valid_o;
   logic [31:0]  dec1_inst_o;
   logic [63:0]  dec1_pc_o;
   logic         dec2_valid_o;
   logic [31:0]  dec2_inst_o;
   logic [63:0]  dec2_pc_o;
   logic [1:0]   dec_accept_i;
   logic [4:0]   occupancy_o;

   int checks = 0;
   int errors = 0;

   logic [63:0] sb_pc[$];
   logic [31:0] sb_inst[$];

   inst_fetch_queue #(.DEPTH(16), .PC_W(64)) dut (
      .clk          (clk),
      .rst          (rst),
      .fq_valid_i   (fq_valid_i),
      .fq_ready_o   (fq_ready_o),
      .fq_pc_i      (fq_pc_i),
      .fq_inst_i    (fq_inst_i),
      .fq_count_i   (fq_count_i),
      .flush_i      (flush_i),
      .dec1_valid_o (dec1_valid_o),
      .dec1_inst_o  (dec1_inst_o),
      .dec1_pc_o    (dec1_pc_o),
      .dec2_valid_o (dec2_valid_o),
      .dec2_inst_o  (dec2_inst_o),
      .dec2_pc_o    (dec2_pc_o),
      .dec_accept_i (dec_accept_i),
      .occupancy_o  (occupancy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [127:0] mkline(input logic [31:0] b);
      return {b + 32'd3, b + 32'd2, b + 32'd1, b};
   endfunction

   // Drives one cycle from a negedge and updates the scoreboard with the expected effect.
   task automatic drive_cycle(input logic v, input logic [63:0] pc, input logic [127:0] line,
                              input logic [2:0] cnt, input logic [1:0] acc, input logic fl);
      int sz, d, c, s0, n;
      fq_valid_i   = v;
      fq_pc_i      = pc;
      fq_inst_i    = line;
      fq_count_i   = cnt;
      dec_accept_i = acc;
      flush_i      = fl;
      sz = sb_pc.size();
      @(posedge clk);
      if (fl) begin
         sb_pc.delete();
         sb_inst.delete();
      end else begin
         d = (acc == 2'b01) ? 1 : (acc == 2'b11) ? 2 : 0;
         if (d > sz) d = sz;
         repeat (d) begin
            void'(sb_pc.pop_front());
            void'(sb_inst.pop_front());
         end
         if (v && (16 - sz) >= 4) begin
            s0 = int'(pc[3:2]);
            c  = (cnt > 3'd4) ? 4 : int'(cnt);
            n  = (c < 4 - s0) ? c : 4 - s0;
            for (int k = 0; k < n; k++) begin
               sb_inst.push_back(line[32*(s0+k) +: 32]);
               sb_pc.push_back(pc + 64'(4 * k));
            end
         end
      end
      @(negedge clk);
      fq_valid_i   = 1'b0;
      dec_accept_i = 2'b00;
      flush_i      = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      sb_pc.delete();
      sb_inst.delete();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (occupancy_o !== 5'd0) begin
         errors++; $display("FAIL reset_occ: got %0d want 0", occupancy_o);
      end
      checks++;
      if (fq_ready_o !== 1'b1) begin
         errors++; $display("FAIL reset_ready: got %b want 1", fq_ready_o);
      end
      checks++;
      if (dec1_valid_o !== 1'b0 || dec2_valid_o !== 1'b0) begin
         errors++; $display("FAIL reset_valid: got %b%b want 00", dec1_valid_o, dec2_valid_o);
      end
      checks++;
      if (dec1_inst_o !== 32'h13 || dec2_inst_o !== 32'h13) begin
         errors++; $display("FAIL reset_nop: got %h %h want 00000013", dec1_inst_o, dec2_inst_o);
      end
      checks++;
      if (dec1_pc_o !== 64'd0 || dec2_pc_o !== 64'd0) begin
         errors++; $display("FAIL reset_pc: got %h %h want 0", dec1_pc_o, dec2_pc_o);
      end
      rst = 1'b0;
      sb_pc.delete();
      sb_inst.delete();
   endtask

   task automatic test_aligned();
      do_reset();
      drive_cycle(1'b1, 64'h8000_0000, mkline(32'hA000_0000), 3'd4, 2'b00, 1'b0);
      checks++;
      if (occupancy_o !== 5'd4) begin
         errors++; $display("FAIL aligned_occ: got %0d want 4", occupancy_o);
      end
      checks++;
      if (dec1_valid_o !== 1'b1 || dec1_inst_o !== 32'hA000_0000 || dec1_pc_o !== 64'h8000_0000)
      begin
         errors++;
         $display("FAIL aligned_dec1: got %b %h@%h want 1 a0000000@80000000",
                  dec1_valid_o, dec1_inst_o, dec1_pc_o);
      end
      checks++;
      if (dec2_valid_o !== 1'b1 || dec2_inst_o !== 32'hA000_0001 || dec2_pc_o !== 64'h8000_0004)
      begin
         errors++;
         $display("FAIL aligned_dec2: got %b %h@%h want 1 a0000001@80000004",
                  dec2_valid_o, dec2_inst_o, dec2_pc_o);
      end
   endtask

   task automatic test_unaligned();
      do_reset();
      drive_cycle(1'b1, 64'h8000_0008, mkline(32'hB000_0000), 3'd4, 2'b00, 1'b0);
      checks++;
      if (occupancy_o !== 5'd2) begin
         errors++; $display("FAIL trunc_occ: got %0d want 2", occupancy_o);
      end
      checks++;
      if (dec1_inst_o !== 32'hB000_0002 || dec1_pc_o !== 64'h8000_0008 ||
          dec2_inst_o !== 32'hB000_0003 || dec2_pc_o !== 64'h8000_000C) begin
         errors++;
         $display("FAIL trunc_entries: got %h@%h %h@%h want b0000002@80000008 b0000003@8000000c",
                  dec1_inst_o, dec1_pc_o, dec2_inst_o, dec2_pc_o);
      end
      do_reset();
      drive_cycle(1'b1, 64'h8000_0004, mkline(32'hC000_0000), 3'd1, 2'b00, 1'b0);
      checks++;
      if (occupancy_o !== 5'd1 || dec1_inst_o !== 32'hC000_0001 || dec1_pc_o !== 64'h8000_0004)
      begin
         errors++;
         $display("FAIL single_entry: got occ %0d %h@%h want 1 c0000001@80000004",
                  occupancy_o, dec1_inst_o, dec1_pc_o);
      end
      checks++;
      if (dec2_valid_o !== 1'b0 || dec2_inst_o !== 32'h13 || dec2_pc_o !== 64'd0) begin
         errors++;
         $display("FAIL single_dec2: got %b %h@%h want 0 00000013@0",
                  dec2_valid_o, dec2_inst_o, dec2_pc_o);
      end
      drive_cycle(1'b1, 64'h8000_0010, mkline(32'hC100_0000), 3'd0, 2'b00, 1'b0);
      checks++;
      if (occupancy_o !== 5'd1) begin
         errors++; $display("FAIL count0_occ: got %0d want 1", occupancy_o);
      end
      drive_cycle(1'b1, 64'h9000_0000, mkline(32'hD000_0000), 3'd7, 2'b00, 1'b0);
      checks++;
      if (occupancy_o !== 5'd5 || dec2_inst_o !== 32'hD000_0000 || dec2_pc_o !== 64'h9000_0000)
      begin
         errors++;
         $display("FAIL count7: got occ %0d dec2 %h@%h want 5 d0000000@90000000",
                  occupancy_o, dec2_inst_o, dec2_pc_o);
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      for (int g = 0; g < 4; g++)
         drive_cycle(1'b1, 64'h2000 + 64'(16 * g), mkline(32'hE000_0000 + 32'(4 * g)), 3'd4,
                     2'b00, 1'b0);
      checks++;
      if (occupancy_o !== 5'd16 || fq_ready_o !== 1'b0) begin
         errors++; $display("FAIL full: got occ %0d ready %b want 16 0", occupancy_o, fq_ready_o);
      end
      drive_cycle(1'b1, 64'h3000, mkline(32'hEE00_0000), 3'd4, 2'b00, 1'b0);
      checks++;
      if (occupancy_o !== 5'd16) begin
         errors++; $display("FAIL full_ignore: got occ %0d want 16", occupancy_o);
      end
      drive_cycle(1'b0, 64'h0, 128'h0, 3'd0, 2'b11, 1'b0);
      checks++;
      if (occupancy_o !== 5'd14 || fq_ready_o !== 1'b0) begin
         errors++; $display("FAIL occ14: got occ %0d ready %b want 14 0", occupancy_o, fq_ready_o);
      end
      drive_cycle(1'b0, 64'h0, 128'h0, 3'd0, 2'b11, 1'b0);
      checks++;
      if (occupancy_o !== 5'd12 || fq_ready_o !== 1'b1) begin
         errors++; $display("FAIL occ12: got occ %0d ready %b want 12 1", occupancy_o, fq_ready_o);
      end
      for (int i = 0; i < 20 && sb_pc.size() > 0; i++) begin
         checks++;
         if (dec1_valid_o !== 1'b1 || dec1_pc_o !== sb_pc[0] || dec1_inst_o !== sb_inst[0]) begin
            errors++;
            $display("FAIL bp_drain_dec1: got %b %h@%h want 1 %h@%h",
                     dec1_valid_o, dec1_inst_o, dec1_pc_o, sb_inst[0], sb_pc[0]);
         end
         if (sb_pc.size() >= 2) begin
            checks++;
            if (dec2_valid_o !== 1'b1 || dec2_pc_o !== sb_pc[1] || dec2_inst_o !== sb_inst[1]) begin
               errors++;
               $display("FAIL bp_drain_dec2: got %b %h@%h want 1 %h@%h",
                        dec2_valid_o, dec2_inst_o, dec2_pc_o, sb_inst[1], sb_pc[1]);
            end
         end
         drive_cycle(1'b0, 64'h0, 128'h0, 3'd0, 2'b11, 1'b0);
      end
      checks++;
      if (sb_pc.size() != 0 || occupancy_o !== 5'd0 || dec1_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL bp_empty: got occ %0d valid %b want 0 0", occupancy_o, dec1_valid_o);
      end
   endtask

   task automatic test_simultaneous();
      do_reset();
      drive_cycle(1'b1, 64'h100, mkline(32'h1100_0000), 3'd4, 2'b00, 1'b0);
      drive_cycle(1'b1, 64'h110, mkline(32'h1200_0000), 3'd2, 2'b00, 1'b0);
      checks++;
      if (occupancy_o !== 5'd6) begin
         errors++; $display("FAIL simul_occ6: got %0d want 6", occupancy_o);
      end
      drive_cycle(1'b1, 64'h120, mkline(32'h1300_0000), 3'd4, 2'b11, 1'b0);
      checks++;
      if (occupancy_o !== 5'd8 || dec1_pc_o !== 64'h108 || dec1_inst_o !== 32'h1100_0002) begin
         errors++;
         $display("FAIL simul_occ8: got occ %0d %h@%h want 8 11000002@108",
                  occupancy_o, dec1_inst_o, dec1_pc_o);
      end
      drive_cycle(1'b0, 64'h0, 128'h0, 3'd0, 2'b10, 1'b0);
      checks++;
      if (occupancy_o !== 5'd8 || dec1_pc_o !== 64'h108) begin
         errors++;
         $display("FAIL accept10: got occ %0d pc %h want 8 108", occupancy_o, dec1_pc_o);
      end
      for (int i = 0; i < 20 && sb_pc.size() > 0; i++) begin
         checks++;
         if (dec1_valid_o !== 1'b1 || dec1_pc_o !== sb_pc[0] || dec1_inst_o !== sb_inst[0]) begin
            errors++;
            $display("FAIL simul_order: got %b %h@%h want 1 %h@%h",
                     dec1_valid_o, dec1_inst_o, dec1_pc_o, sb_inst[0], sb_pc[0]);
         end
         drive_cycle(1'b0, 64'h0, 128'h0, 3'd0, 2'b01, 1'b0);
      end
      checks++;
      if (sb_pc.size() != 0 || occupancy_o !== 5'd0) begin
         errors++; $display("FAIL simul_empty: got occ %0d want 0", occupancy_o);
      end
   endtask

   task automatic test_wrap();
      int g;
      int popped;
      logic [63:0] exp_pc;
      logic v;
      do_reset();
      g = 0;
      exp_pc = 64'h4000;
      for (int cyc = 0; cyc < 100 && (g < 10 || sb_pc.size() > 0); cyc++) begin
         if (dec1_valid_o === 1'b1 || sb_pc.size() > 0) begin
            checks++;
            if (dec1_valid_o !== 1'b1 || dec1_pc_o !== exp_pc || dec1_inst_o !== sb_inst[0]) begin
               errors++;
               $display("FAIL wrap_dec1: got %b %h@%h want 1 %h@%h",
                        dec1_valid_o, dec1_inst_o, dec1_pc_o, sb_inst[0], exp_pc);
            end
         end
         if (sb_pc.size() >= 2) begin
            checks++;
            if (dec2_valid_o !== 1'b1 || dec2_pc_o !== exp_pc + 64'd4) begin
               errors++;
               $display("FAIL wrap_dec2: got %b %h want 1 %h", dec2_valid_o, dec2_pc_o,
                        exp_pc + 64'd4);
            end
         end
         v = (g < 10) && (sb_pc.size() <= 12);
         popped = (sb_pc.size() < 2) ? sb_pc.size() : 2;
         drive_cycle(v, 64'h4000 + 64'(16 * g), mkline(32'h5000_0000 + 32'(4 * g)), 3'd4,
                     2'b11, 1'b0);
         exp_pc = exp_pc + 64'(4 * popped);
         if (v) g++;
      end
      checks++;
      if (g != 10 || sb_pc.size() != 0 || occupancy_o !== 5'd0 || exp_pc !== 64'h40A0) begin
         errors++;
         $display("FAIL wrap_done: got groups %0d occ %0d pc %h want 10 0 40a0",
                  g, occupancy_o, exp_pc);
      end
   endtask

   task automatic test_flush();
      do_reset();
      drive_cycle(1'b1, 64'h6000, mkline(32'h6000_0000), 3'd4, 2'b00, 1'b0);
      drive_cycle(1'b1, 64'h6010, mkline(32'h6000_0004), 3'd4, 2'b00, 1'b0);
      drive_cycle(1'b1, 64'h6020, mkline(32'h6000_0008), 3'd1, 2'b00, 1'b0);
      checks++;
      if (occupancy_o !== 5'd9) begin
         errors++; $display("FAIL flush_pre: got %0d want 9", occupancy_o);
      end
      drive_cycle(1'b1, 64'h6030, mkline(32'h6000_000C), 3'd4, 2'b11, 1'b1);
      checks++;
      if (occupancy_o !== 5'd0 || dec1_valid_o !== 1'b0 || dec2_valid_o !== 1'b0 ||
          dec1_inst_o !== 32'h13 || fq_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL flush_post: got occ %0d valid %b%b inst %h ready %b want 0 00 13 1",
                  occupancy_o, dec1_valid_o, dec2_valid_o, dec1_inst_o, fq_ready_o);
      end
      drive_cycle(1'b1, 64'h7000, mkline(32'h7000_0000), 3'd4, 2'b00, 1'b0);
      drive_cycle(1'b1, 64'h7010, mkline(32'h7000_0004), 3'd4, 2'b00, 1'b0);
      rst          = 1'b1;
      fq_valid_i   = 1'b1;
      fq_pc_i      = 64'h7020;
      fq_inst_i    = mkline(32'h7000_0008);
      fq_count_i   = 3'd4;
      dec_accept_i = 2'b11;
      @(posedge clk);
      sb_pc.delete();
      sb_inst.delete();
      @(negedge clk);
      rst          = 1'b0;
      fq_valid_i   = 1'b0;
      dec_accept_i = 2'b00;
      checks++;
      if (occupancy_o !== 5'd0 || dec1_valid_o !== 1'b0 || dec2_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid: got occ %0d valid %b%b want 0 00",
                  occupancy_o, dec1_valid_o, dec2_valid_o);
      end
      checks++;
      if (dec1_inst_o !== 32'h13 || dec2_inst_o !== 32'h13 ||
          dec1_pc_o !== 64'd0 || dec2_pc_o !== 64'd0) begin
         errors++;
         $display("FAIL rst_mid_nop: got %h@%h %h@%h want 00000013@0",
                  dec1_inst_o, dec1_pc_o, dec2_inst_o, dec2_pc_o);
      end
      drive_cycle(1'b1, 64'h7100, mkline(32'h7100_0000), 3'd4, 2'b00, 1'b0);
      checks++;
      if (occupancy_o !== 5'd4 || dec1_pc_o !== 64'h7100 || dec1_inst_o !== 32'h7100_0000) begin
         errors++;
         $display("FAIL after_rst: got occ %0d %h@%h want 4 71000000@7100",
                  occupancy_o, dec1_inst_o, dec1_pc_o);
      end
   endtask

   initial begin
      rst          = 1'b1;
      fq_valid_i   = 1'b0;
      fq_pc_i      = 64'h0;
      fq_inst_i    = 128'h0;
      fq_count_i   = 3'd0;
      flush_i      = 1'b0;
      dec_accept_i = 2'b00;
      @(negedge clk);
      test_reset();
      test_aligned();
      test_unaligned();
      test_backpressure();
      test_simultaneous();
      test_wrap();
      test_flush();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
Decoupling buffer between the fetch-address generator / I-cache and the dual-issue decode stage.
- Input side: each accepted fetch delivers one 128-bit line (four 32-bit slots), the PC of the first valid slot, and a valid-instruction count. This is the line/pc_counter pair the fetch unit produces.
- Storage: the valid slots are unpacked into a circular queue of {pc, inst} entries.
- Output side: the two oldest entries are presented to decoder 1 and decoder 2 in program order.
- Flush: a redirect from decode or trap empties the queue.

Parameters:
- DEPTH, 16, number of queue entries; power of two, at least 8.
- PC_W, 64, PC width.

Ports:
- clk  input  1  clock
- rst  input  1  reset; synchronous, active-high
- fq_valid_i  input  1  fetch group valid
- fq_ready_o  output  1  queue can accept a full group (at least 4 free entries)
- fq_pc_i  input  PC_W  PC of first valid slot; bits [3:2] select the start slot
- fq_inst_i  input  128  fetch line; slot s = bits [32s+31:32s]
- fq_count_i  input  3  number of valid instructions, 0..4
- flush_i  input  1  redirect; discard all contents
- dec1_valid_o  output  1  oldest entry valid
- dec1_inst_o  output  32  oldest instruction
- dec1_pc_o  output  PC_W  oldest PC
- dec2_valid_o  output  1  second-oldest entry valid
- dec2_inst_o  output  32  second-oldest instruction
- dec2_pc_o  output  PC_W  second-oldest PC
- dec_accept_i  input  2  decode consumption: 00 none, 01 dec1 only, 11 both
- occupancy_o  output  log2(DEPTH)+1  current number of entries

Behaviour:
- Reset:
  - head = tail = 0, occupancy_o = 0, fq_ready_o = 1.
  - dec1_valid_o = dec2_valid_o = 0.
  - Inst outputs = 32'h00000013 (NOP), PC outputs = 0.
  - The same values apply whenever the corresponding output is invalid.
- Reset asserted mid-operation has the same effect as flush, and takes priority over it.
- Enqueue fire: fq_valid_i & fq_ready_o & ~flush_i.
  - fq_ready_o = (DEPTH - occupancy) >= 4, computed from the current-cycle occupancy.
- Write count:
  - start slot s0 = fq_pc_i[3:2].
  - n = min(fq_count_i, 4 - s0); n is the clamped count.
  - fq_count_i > 4 is treated as 4 before clamping.
  - n = 0: the group is accepted but nothing is written.
- Entry k (k = 0..n-1) is written at tail+k mod DEPTH:
  - inst = slot s0+k.
  - pc = fq_pc_i + 4k, computed modulo 2^PC_W.
  - tail advances by n.
- Latency: an entry written at edge t is visible on dec1/dec2 after edge t; no combinational input-to-output bypass.
- Outputs:
  - Combinational reads of entries head and head+1 (mod DEPTH).
  - dec1_valid_o = occupancy >= 1.
  - dec2_valid_o = occupancy >= 2.
- Dequeue count:
  - d = dec_accept_i[0] + (dec_accept_i[0] & dec_accept_i[1]).
  - 10 is treated as 00.
  - Acceptance of an invalid output is ignored, so d is clamped to occupancy.
  - head advances by d.
- Simultaneous enqueue and dequeue: next occupancy = occupancy + n - d.
  - Enqueue eligibility uses the pre-dequeue occupancy.
  - The queue never overflows.
- Wrap-around: both pointers wrap modulo DEPTH. A group may straddle the wrap boundary.
- Flush: highest priority after rst. On the next edge, head = tail = occupancy = 0; the same-cycle enqueue and dequeue are discarded.
- Full state: occupancy > DEPTH-4 gives fq_ready_o = 0; dequeue continues. Empty state: both valids are 0.
- Program-order invariant: dec2 is never valid while dec1 is invalid.

Test Plan:
- Aligned group: pc=0x80000000, count=4, inst={I3,I2,I1,I0}, no accept -> occupancy 4; dec1=I0@0x80000000, dec2=I1@0x80000004.
- Unaligned/truncated group: pc=0x80000008, count=4 -> clamped to 2; entries I2@0x80000008, I3@0x8000000C. Also pc=0x80000004, count=1 -> single entry.
- Backpressure with DEPTH=16: four aligned groups (occupancy 16) -> fq_ready_o=0, further valids ignored. One accept=11 leaves occupancy 14, still not ready; after two accept=11 cycles, occupancy 12 and ready=1.
- Simultaneous operation: occupancy 6, enqueue count=4 with accept=11 in the same cycle -> occupancy 8, order preserved. accept=10 -> no dequeue.
- Wrap-around: stream 10 aligned groups while accepting 2 per cycle -> the PC sequence at dec1 is strictly +4 with no gaps or duplicates across the pointer wrap.
- Flush: occupancy 9 with flush_i plus a simultaneous valid group -> next cycle occupancy 0, both valids 0, group dropped. rst mid-stream -> same result, with outputs at NOP/0.
